ft_fpu_bus_queue: RTL and testbench

Next-generation bus front-end for the sequential FPU core on the 65816-style peripheral bus (ph2/cs/rw/vda, byte-lane data). Unlike the single-shot register wrapper, it queues commands: each completed instruction write snapshots {instruction, operand} into a CMD_DEPTH-deep FIFO. A sequencer issues queued commands to the FPU core with a start/done handshake, latches results, and raises a maskable interrupt. Bus width, operand width and queue depth are parametrised.

---
 rtl/ft_fpu_bus_pkg.sv | 52 +++++
 rtl/ft_fpu_cmd_fifo.sv | 75 +++++++
 rtl/ft_fpu_bus_queue.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ft_fpu_bus_queue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_fpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ft_fpu_bus_pkg
//  Purpose  : Shared constants and types for the queued FPU bus front-end:
//             register map, status/control bit positions, sequencer states
//             and the default command layout.
//  Revision : 1.0  initial release
// ============================================================================
package ft_fpu_bus_pkg;

    // Default command field widths (match the top-level parameter defaults)
    localparam int CMD_IR_W = 24;
    localparam int CMD_OP_W = 48;

    // Register map (lane addresses 0..7 are operand/result lanes)
    localparam logic [3:0] ADDR_IR0    = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;
    localparam logic [3:0] ADDR_CTRL   = 4'hD;
    localparam logic [3:0] ADDR_SR     = 4'hE;
    localparam logic [3:0] ADDR_CNT    = 4'hF;

    // Status register bit positions
    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_DONE   = 3;
    localparam int ST_OVF    = 4;
    localparam int ST_TMO    = 5;
    localparam int ST_IRQ_EN = 6;
    localparam int ST_IRQ    = 7;

    // Control register bit positions
    localparam int CTL_IRQ_EN = 0;
    localparam int CTL_CLEAR  = 1;
    localparam int CTL_FLUSH  = 7;

    // Command sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Queued command in the default configuration
    typedef struct packed {
        logic [CMD_IR_W-1:0] ir;
        logic [CMD_OP_W-1:0] opnd;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/ft_fpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ft_fpu_cmd_fifo
//  Purpose  : Small synchronous command FIFO with flush. A push while full
//             is accepted when a pop happens in the same cycle. Flush
//             empties the queue and discards a concurrent push.
//  Revision : 1.0  initial release
// ============================================================================
module ft_fpu_cmd_fifo
    import ft_fpu_bus_pkg::*;
#(
    parameter int WIDTH = CMD_IR_W + CMD_OP_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A full queue still takes a push when the head leaves in the same cycle
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    // Pointer, occupancy and storage update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ft_fpu_bus_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ft_fpu_bus_queue
//  Purpose  : Queued bus front-end for the sequential FPU core. Bus writes
//             build {instruction, operand}; the write of the last IR lane
//             enqueues it. A sequencer issues commands with a start/done
//             handshake, latches results and drives a maskable interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module ft_fpu_bus_queue
    import ft_fpu_bus_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OP_W      = CMD_OP_W,
    parameter int IR_W      = CMD_IR_W,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ph2,
    input  logic              cs,
    input  logic              rw,
    input  logic              vda,
    input  logic [3:0]        ad,
    input  logic [DATA_W-1:0] db_i,
    output logic [DATA_W-1:0] db_o,
    output logic              db_oe,
    output logic              irq,
    output logic              fpu_start,
    output logic [IR_W-1:0]   fpu_ir,
    output logic [OP_W-1:0]   fpu_a,
    input  logic              fpu_done,
    input  logic [OP_W-1:0]   fpu_o,
    input  logic [7:0]        fpu_sr
);

    localparam int         N_OP         = OP_W / DATA_W;
    localparam int         N_IR         = (IR_W + DATA_W - 1) / DATA_W;
    localparam int         IRP_W        = N_IR * DATA_W;
    localparam int         CMD_W        = IR_W + OP_W;
    localparam int         TW           = $clog2(TIMEOUT + 1);
    localparam int         CW           = $clog2(CMD_DEPTH) + 1;
    localparam logic [3:0] ADDR_IR_LAST = ADDR_IR0 + 4'(N_IR - 1);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [OP_W-1:0] opnd;
    } q_cmd_t;

    seq_state_e        r_state;
    seq_state_e        w_state_next;
    logic              r_ph2_q;
    logic [OP_W-1:0]   r_opnd;
    logic [IRP_W-1:0]  r_ir;
    logic [IRP_W-1:0]  w_ir_next;
    q_cmd_t            r_hold;
    logic [OP_W-1:0]   r_result;
    logic [7:0]        r_sr;
    logic [DATA_W-1:0] r_opcnt;
    logic [TW-1:0]     r_wcnt;
    logic              r_done;
    logic              r_ovf;
    logic              r_tmo;
    logic              r_irq_en;
    logic              r_irq;

    logic              w_wr;
    logic              w_push;
    logic              w_ctrl_wr;
    logic              w_flush;
    logic              w_clear;
    logic              w_pop;
    logic              w_latch;
    logic              w_set_done;
    logic              w_set_tmo;
    logic              w_set_ovf;
    q_cmd_t            w_push_cmd;
    logic [CMD_W-1:0]  w_fifo_dout;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic [7:0]        w_status;

    // Bus decode: a write lands on the falling edge of ph2
    assign w_wr      = r_ph2_q & ~ph2 & cs & vda & ~rw;
    assign w_ctrl_wr = w_wr & (ad == ADDR_CTRL);
    assign w_flush   = w_ctrl_wr & db_i[CTL_FLUSH];
    assign w_clear   = w_ctrl_wr & db_i[CTL_CLEAR];
    assign w_push    = w_wr & (ad == ADDR_IR_LAST);
    assign db_oe     = cs & vda & rw;

    // The enqueued IR must include the lane being written this cycle
    always_comb begin
        w_ir_next = r_ir;
        for (int k = 0; k < N_IR; k++) begin
            if (w_wr && (ad == ADDR_IR0 + 4'(k))) begin
                w_ir_next[k*DATA_W +: DATA_W] = db_i;
            end
        end
    end

    assign w_push_cmd.ir   = w_ir_next[IR_W-1:0];
    assign w_push_cmd.opnd = r_opnd;

    // A push lost to a full queue (and not rescued by a pop) is an overflow
    assign w_set_ovf = w_push & w_fifo_full & ~w_pop & ~w_flush;

    ft_fpu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_push_cmd),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Bus-side registers: ph2 history, staging lanes, control and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ph2_q  <= 1'b0;
            r_opnd   <= '0;
            r_ir     <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_tmo    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ph2_q <= ph2;
            r_ir    <= w_ir_next;
            for (int k = 0; k < N_OP; k++) begin
                if (w_wr && (ad == 4'(k))) begin
                    r_opnd[k*DATA_W +: DATA_W] <= db_i;
                end
            end
            if (w_ctrl_wr) begin
                r_irq_en <= db_i[CTL_IRQ_EN];
            end
            if (w_clear) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
                r_tmo  <= 1'b0;
            end
            if (w_set_done) r_done <= 1'b1;
            if (w_set_ovf)  r_ovf  <= 1'b1;
            if (w_set_tmo)  r_tmo  <= 1'b1;
            r_irq <= r_irq_en & (r_done | r_tmo);
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sequencer next-state and strobes
    always_comb begin
        w_state_next = r_state;
        fpu_start    = 1'b0;
        w_pop        = 1'b0;
        w_latch      = 1'b0;
        w_set_done   = 1'b0;
        w_set_tmo    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                fpu_start    = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (fpu_done) begin
                    w_latch      = 1'b1;
                    w_state_next = DONE;
                end else if (r_wcnt == TW'(TIMEOUT - 1)) begin
                    w_set_tmo    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            DONE: begin
                w_set_done   = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Sequencer datapath: command hold, wait counter, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold   <= '0;
            r_wcnt   <= '0;
            r_result <= '0;
            r_sr     <= '0;
            r_opcnt  <= '0;
        end else begin
            if (w_pop) begin
                r_hold <= q_cmd_t'(w_fifo_dout);
            end
            if (r_state == WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end else begin
                r_wcnt <= '0;
            end
            if (w_latch) begin
                r_result <= fpu_o;
                r_sr     <= fpu_sr;
            end
            if (w_set_done) begin
                r_opcnt <= r_opcnt + 1'b1;
            end
        end
    end

    assign fpu_ir = r_hold.ir;
    assign fpu_a  = r_hold.opnd;
    assign irq    = r_irq;

    assign w_status[ST_BUSY]   = (r_state != IDLE) | (w_fifo_count != '0);
    assign w_status[ST_FULL]   = w_fifo_full;
    assign w_status[ST_EMPTY]  = w_fifo_empty;
    assign w_status[ST_DONE]   = r_done;
    assign w_status[ST_OVF]    = r_ovf;
    assign w_status[ST_TMO]    = r_tmo;
    assign w_status[ST_IRQ_EN] = r_irq_en;
    assign w_status[ST_IRQ]    = r_irq;

    // Read mux; unmapped addresses return zero
    always_comb begin
        db_o = '0;
        for (int k = 0; k < N_OP; k++) begin
            if (ad == 4'(k)) db_o = r_result[k*DATA_W +: DATA_W];
        end
        for (int k = 0; k < N_IR; k++) begin
            if (ad == ADDR_IR0 + 4'(k)) db_o = r_ir[k*DATA_W +: DATA_W];
        end
        case (ad)
            ADDR_STATUS: db_o = DATA_W'(w_status);
            ADDR_CTRL:   db_o = DATA_W'(r_irq_en);
            ADDR_SR:     db_o = DATA_W'(r_sr);
            ADDR_CNT:    db_o = r_opcnt;
            default:     ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ft_fpu_bus_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ft_fpu_bus_queue
//  Purpose  : Self-checking bench for ft_fpu_bus_queue with a behavioural
//             FPU core and a scoreboard of expected issued commands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ft_fpu_bus_queue;

    logic        clk = 1'b0;
    logic        rst, ph2, cs, rw, vda;
    logic [3:0]  ad;
    logic [7:0]  db_i, db_o;
    logic        db_oe, irq, fpu_start, fpu_done;
    logic [23:0] fpu_ir;
    logic [47:0] fpu_a, fpu_o;
    logic [7:0]  fpu_sr;

    ft_fpu_bus_queue #(
        .DATA_W(8), .OP_W(48), .IR_W(24), .CMD_DEPTH(4), .TIMEOUT(1023)
    ) dut (
        .clk(clk), .rst(rst), .ph2(ph2), .cs(cs), .rw(rw), .vda(vda),
        .ad(ad), .db_i(db_i), .db_o(db_o), .db_oe(db_oe), .irq(irq),
        .fpu_start(fpu_start), .fpu_ir(fpu_ir), .fpu_a(fpu_a),
        .fpu_done(fpu_done), .fpu_o(fpu_o), .fpu_sr(fpu_sr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] ir;
        logic [47:0] a;
    } cmd_s;

    cmd_s        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_start  = 0;
    int          cyc      = 0;
    int          start_cyc = 0;
    bit          core_en  = 1'b1;
    bit          core_mute = 1'b0;
    bit          inject_done = 1'b0;
    int          core_lat = 10;
    bit          core_pend;
    int          core_lc;
    logic [47:0] core_op;

    localparam logic [47:0] RES_ADD = 48'h0080_0000_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every issue pulse must match the oldest expected command
    initial begin
        cmd_s e;
        forever begin
            @(negedge clk);
            if (fpu_start === 1'b1) begin
                n_start++;
                start_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("issue_ir", fpu_ir, e.ir);
                    check("issue_a", fpu_a, e.a);
                end
            end
        end
    end

    // Behavioural FPU core: result = operand + RES_ADD after core_lat cycles
    initial begin
        core_pend = 1'b0; core_lc = 0; core_op = '0;
        fpu_done = 1'b0; fpu_o = '0; fpu_sr = '0;
        forever begin
            @(negedge clk);
            fpu_done = 1'b0;
            if (rst) begin
                core_pend = 1'b0;
            end else if (inject_done) begin
                fpu_done = 1'b1;
                fpu_o    = 48'hDEAD_BEEF_0001;
                fpu_sr   = 8'hEE;
            end else if (core_pend && core_en) begin
                if (core_lc > 1) begin
                    core_lc--;
                end else begin
                    fpu_done  = 1'b1;
                    fpu_o     = core_op + RES_ADD;
                    fpu_sr    = core_op[7:0] ^ 8'h5A;
                    core_pend = 1'b0;
                end
            end
            if (!rst && fpu_start === 1'b1 && !core_mute) begin
                core_pend = 1'b1;
                core_lc   = core_lat;
                core_op   = fpu_a;
            end
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; vda = 1'b1; rw = 1'b0; ad = a; db_i = d; ph2 = 1'b1;
        @(negedge clk);
        ph2 = 1'b0;
        @(negedge clk);
        cs = 1'b0; vda = 1'b0; rw = 1'b1;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; vda = 1'b1; rw = 1'b1; ad = a;
        #1;
        d = db_o;
        cs = 1'b0; vda = 1'b0;
    endtask

    task automatic enqueue(input logic [23:0] ir, input logic [47:0] a, input bit accept);
        cmd_s c;
        for (int k = 0; k < 6; k++) bus_wr(4'(k), a[k*8 +: 8]);
        bus_wr(4'h8, ir[7:0]);
        bus_wr(4'h9, ir[15:8]);
        if (accept) begin
            c.ir = ir;
            c.a  = a;
            sb_q.push_back(c);
        end
        bus_wr(4'hA, ir[23:16]);
    endtask

    task automatic read_result(output logic [47:0] r);
        logic [7:0] d;
        for (int k = 0; k < 6; k++) begin
            bus_rd(4'(k), d);
            r[k*8 +: 8] = d;
        end
    endtask

    task automatic wait_ops(input int n, input int budget);
        logic [7:0] d;
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            bus_rd(4'hF, d);
            if (d == 8'(n)) got = 1'b1;
        end
        if (!got) check("wait_ops_timeout", d, 8'(n));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [47:0] r, last_res, a4;
        int          s0, t_a;
        bit          got;

        rst = 1'b1; ph2 = 1'b0; cs = 1'b0; rw = 1'b1; vda = 1'b0; ad = '0; db_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        bus_rd(4'hC, d);  check("rst_status", d, 8'h04);
        check("rst_irq", irq, 0);
        check("rst_starts", n_start, 0);
        check("rst_fpu_a", fpu_a, 48'h0);
        @(negedge clk);
        cs = 1'b1; vda = 1'b1; rw = 1'b1; #1 check("db_oe_read", db_oe, 1);
        rw = 1'b0; #1 check("db_oe_write", db_oe, 0);
        cs = 1'b0; vda = 1'b0; rw = 1'b1;

        // Single command round trip
        core_lat = 10; s0 = n_start;
        enqueue(24'h030201, 48'h3F80_0000_0000, 1'b1);
        wait_ops(1, 60);
        check("t1_starts", n_start - s0, 1);
        read_result(r);   check("t1_result", r, 48'h4000_0000_0000);
        bus_rd(4'hC, d);  check("t1_status", d, 8'h0C);
        bus_rd(4'hF, d);  check("t1_opcnt", d, 8'd1);
        bus_rd(4'hE, d);  check("t1_sr", d, 8'h5A);
        bus_rd(4'h9, d);  check("t1_ir_readback", d, 8'h02);

        // Overflow with a stalled core, then drain in order
        bus_wr(4'hD, 8'h02);
        core_en = 1'b0; core_lat = 3; s0 = n_start;
        for (int i = 0; i < 6; i++) begin
            enqueue(24'h100000 + 24'(i), 48'hA000_0000_0000 + 48'(i) * 48'h1_0000_0001, i < 5);
        end
        bus_rd(4'hC, d);  check("t3_full_ovf", d, 8'h13);
        check("t3_one_issued", n_start - s0, 1);
        core_en = 1'b1;
        wait_ops(6, 200);
        check("t3_starts", n_start - s0, 5);
        check("t3_sb_empty", sb_q.size(), 0);
        bus_rd(4'hC, d);  check("t3_status_end", d, 8'h1C);
        read_result(r);
        check("t3_last_result", r, 48'hA000_0000_0000 + 48'd4 * 48'h1_0000_0001 + RES_ADD);

        // Interrupt lag and clear
        core_lat = 5;
        bus_wr(4'hD, 8'h03);
        @(negedge clk); #1 check("t4_irq_off", irq, 0);
        a4 = 48'h1234_5678_9ABC;
        enqueue(24'h0A0B0C, a4, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            bus_rd(4'hC, d);
            if (d[3]) got = 1'b1;
        end
        check("t4_done_seen", got, 1);
        check("t4_irq_lag", irq, 0);
        @(negedge clk); #1 check("t4_irq_set", irq, 1);
        bus_wr(4'hD, 8'h03);
        check("t4_irq_hold", irq, 1);
        @(negedge clk); #1 check("t4_irq_cleared", irq, 0);
        last_res = a4 + RES_ADD;

        // Timeout: first command never completes, second one follows
        core_mute = 1'b1; core_lat = 20; s0 = n_start;
        enqueue(24'h0F0E0D, 48'h0000_1111_2222, 1'b1);
        enqueue(24'h050607, 48'h7777_8888_9999, 1'b1);
        t_a = start_cyc;
        core_mute = 1'b0;
        check("t5_one_issued", n_start - s0, 1);
        got = 1'b0;
        for (int i = 0; i < 1500 && !got; i++) begin
            bus_rd(4'hC, d);
            if (d[5]) got = 1'b1;
        end
        check("t5_tmo_seen", got, 1);
        check("t5_tmo_window", ((cyc - t_a) >= 1000) && ((cyc - t_a) <= 1100), 1);
        read_result(r);   check("t5_result_kept", r, last_res);
        wait_ops(8, 100);
        check("t5_starts", n_start - s0, 2);
        read_result(r);   check("t5_next_result", r, 48'h7777_8888_9999 + RES_ADD);
        bus_rd(4'hE, d);  check("t5_sr", d, 8'h99 ^ 8'h5A);
        check("t5_irq", irq, 1);

        // Reset during WAIT abandons everything; a late done is ignored
        core_en = 1'b0; core_lat = 3;
        for (int i = 0; i < 3; i++) enqueue(24'h200000 + 24'(i), 48'h5555_0000_0000 + 48'(i), 1'b1);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        s0 = n_start;
        core_en = 1'b1;
        bus_rd(4'hC, d);  check("t6_status", d, 8'h04);
        bus_rd(4'hF, d);  check("t6_opcnt", d, 8'h00);
        bus_rd(4'hD, d);  check("t6_ctrl", d, 8'h00);
        read_result(r);   check("t6_result", r, 48'h0);
        check("t6_fpu_ir", fpu_ir, 24'h0);
        check("t6_irq", irq, 0);
        @(negedge clk); #1 inject_done = 1'b1;
        @(negedge clk); #1 inject_done = 1'b0;
        repeat (5) @(negedge clk);
        bus_rd(4'hC, d);  check("t6_status_after", d, 8'h04);
        bus_rd(4'hF, d);  check("t6_opcnt_after", d, 8'h00);
        bus_rd(4'hE, d);  check("t6_sr_after", d, 8'h00);
        read_result(r);   check("t6_result_after", r, 48'h0);
        check("t6_no_start", n_start - s0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
